// File: rtl/seq_pkg.sv
// Shared definitions for the 4-state C->Y sequence walk 0->1->3->2->0,
// used by both the receiver and its transmit-side driver.
package seq_pkg;

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S3 = 2'd3;
    localparam logic [1:0] S2 = 2'd2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRIVE   = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    function automatic logic [1:0] seq_next(input logic [1:0] state, input logic c);
        case (state)
            S0:      return c ? S1 : S0;
            S1:      return c ? S1 : S3;
            S3:      return c ? S2 : S3;
            S2:      return c ? S2 : S0;
            default: return state;
        endcase
    endfunction

    // Mealy output: in S2 the receiver's Y follows C combinationally.
    function automatic logic seq_y(input logic [1:0] state, input logic c);
        case (state)
            S3:      return 1'b1;
            S2:      return c;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_model.sv
// Mirror of the receiver's sequence state plus its predicted Y output.
module seq_model
    import seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       c_in,
    output logic [1:0] mstate,
    output logic       pred_y
);

    logic [1:0] mstate_q, mstate_d;

    always_comb begin
        mstate_d = seq_next(mstate_q, c_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstate_q <= S0;
        end else begin
            mstate_q <= mstate_d;
        end
    end

    assign mstate = mstate_q;
    assign pred_y = seq_y(mstate_q, c_in);

endmodule

// File: rtl/seq_circuit_driver.sv
// Drives serial C so the receiver completes N full 0->1->3->2->0 loops, and
// checks the receiver's Y against a mirror model every cycle.
module seq_circuit_driver
    import seq_pkg::*;
#(
    parameter int CW   = 8,
    parameter int HOLD = 0,
    parameter int EW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] cycles,
    input  logic          abort,
    input  logic          y_in,
    input  logic          chk_en,
    input  logic          clr_err,
    output logic          c_out,
    output logic          busy,
    output logic          done,
    output logic [1:0]    mstate,
    output logic          mismatch,
    output logic [EW-1:0] err_cnt
);

    localparam int DW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

    logic [1:0]    fsm_q, fsm_d;
    logic          c_q, c_d;
    logic          done_q, done_d;
    logic [CW-1:0] loops_q, loops_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    level_q, level_d;
    logic          mismatch_q, mismatch_d;
    logic [EW-1:0] err_cnt_q, err_cnt_d;

    logic [1:0] mstate_w;
    logic       pred_y;
    logic       level_end;
    logic       loop_end;

    seq_model u_model (
        .clk    (clk),
        .rst_n  (rst_n),
        .c_in   (c_q),
        .mstate (mstate_w),
        .pred_y (pred_y)
    );

    assign level_end = (dwell_q == DW'(HOLD));
    assign loop_end  = level_end && (level_q == 2'd3);

    // Level 3 ending means the receiver is back in S0, so a loop boundary is
    // the only safe point to leave DRIVE/RECOVER.
    always_comb begin
        fsm_d   = fsm_q;
        c_d     = c_q;
        done_d  = 1'b0;
        loops_d = loops_q;
        dwell_d = dwell_q;
        level_d = level_q;
        case (fsm_q)
            ST_IDLE: begin
                c_d = 1'b0;
                if (start && (mstate_w == S0)) begin
                    if (cycles == '0) begin
                        done_d = 1'b1;
                    end else begin
                        fsm_d   = ST_DRIVE;
                        c_d     = 1'b1;
                        loops_d = cycles;
                        dwell_d = '0;
                        level_d = 2'd0;
                    end
                end
            end
            ST_DRIVE, ST_RECOVER: begin
                if (!level_end) begin
                    dwell_d = dwell_q + DW'(1);
                end else begin
                    dwell_d = '0;
                    if (level_q != 2'd3) begin
                        level_d = level_q + 2'd1;
                        c_d     = ~c_q;
                    end else begin
                        level_d = 2'd0;
                        if ((fsm_q == ST_DRIVE) && !abort && (loops_q != CW'(1))) begin
                            loops_d = loops_q - CW'(1);
                            c_d     = 1'b1;
                        end else begin
                            fsm_d  = ST_IDLE;
                            c_d    = 1'b0;
                            done_d = (fsm_q == ST_DRIVE) && !abort;
                        end
                    end
                end
                if ((fsm_q == ST_DRIVE) && abort && !loop_end) begin
                    fsm_d = ST_RECOVER;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
                c_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        mismatch_d = mismatch_q;
        err_cnt_d  = err_cnt_q;
        if (clr_err) begin
            mismatch_d = 1'b0;
            err_cnt_d  = '0;
        end else if (chk_en && (y_in != pred_y)) begin
            mismatch_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + EW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= ST_IDLE;
            c_q        <= 1'b0;
            done_q     <= 1'b0;
            loops_q    <= '0;
            dwell_q    <= '0;
            level_q    <= 2'd0;
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            fsm_q      <= fsm_d;
            c_q        <= c_d;
            done_q     <= done_d;
            loops_q    <= loops_d;
            dwell_q    <= dwell_d;
            level_q    <= level_d;
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign c_out    = c_q;
    assign busy     = (fsm_q != ST_IDLE);
    assign done     = done_q;
    assign mstate   = mstate_w;
    assign mismatch = mismatch_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_seq_circuit_driver.sv
// Scoreboard bench: a behavioural receiver plus run-level expectations
// (busy length, done) queued at start and popped at every run-end event.
module tb_seq_circuit_driver;

    localparam int HOLD = 2;
    localparam int H    = HOLD + 1;

    typedef struct {
        int busy_len;
        bit done;
    } exp_rec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] cycles;
    logic       abort;
    logic       y_in;
    logic       chk_en;
    logic       clr_err;
    logic       c_out;
    logic       busy;
    logic       done;
    logic [1:0] mstate;
    logic       mismatch;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    exp_rec_t sb[$];

    int   rx_pos;
    logic [1:0] rx_state;
    logic rx_y;
    logic fault_on;
    logic fault_val;
    int   exp_err;
    int   exp_mismatch;

    int   busy_idx;
    logic busy_prev;

    seq_circuit_driver #(.CW(8), .HOLD(HOLD), .EW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cycles   (cycles),
        .abort    (abort),
        .y_in     (y_in),
        .chk_en   (chk_en),
        .clr_err  (clr_err),
        .c_out    (c_out),
        .busy     (busy),
        .done     (done),
        .mstate   (mstate),
        .mismatch (mismatch),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int walk_state(input int p);
        int w[4] = '{0, 1, 3, 2};
        return w[p];
    endfunction

    // Receiver: walks positions 0..3 of 0->1->3->2; it advances when C equals
    // 1 at even positions and 0 at odd positions.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_pos <= 0;
        end else if (c_out == ((rx_pos % 2) == 0)) begin
            rx_pos <= (rx_pos + 1) % 4;
        end
    end

    assign rx_state = 2'(walk_state(rx_pos));
    assign rx_y     = (rx_state == 2'd3) ? 1'b1 : (rx_state == 2'd2) ? c_out : 1'b0;
    assign y_in     = fault_on ? fault_val : rx_y;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_err      <= 0;
            exp_mismatch <= 0;
        end else if (clr_err) begin
            exp_err      <= 0;
            exp_mismatch <= 0;
        end else if (chk_en && (y_in != rx_y)) begin
            exp_mismatch <= 1;
            if (exp_err < 255) exp_err <= exp_err + 1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: per-cycle output checks plus run-end events for the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0;
            busy_idx  = 0;
        end else begin
            checkOutput("c_out", int'(c_out), busy ? int'(((busy_idx / H) % 2) == 0) : 0);
            checkOutput("mstate", int'(mstate), int'(rx_state));
            checkOutput("mismatch", int'(mismatch), exp_mismatch);
            checkOutput("err_cnt", int'(err_cnt), exp_err);
            if (busy) checkOutput("done_while_busy", int'(done), 0);
            if ((busy_prev && !busy) || (done && !busy_prev)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_event: got unexpected run end at %0t, expected none", $time);
                end else begin
                    exp_rec_t e;
                    e = sb.pop_front();
                    checkOutput("busy_len", busy_idx, e.busy_len);
                    checkOutput("done", int'(done), int'(e.done));
                end
                busy_idx = 0;
            end
            if (busy) busy_idx++;
            busy_prev = busy;
        end
    end

    // One run: an abort at wait index w is sampled at the end of busy cycle w;
    // the run still finishes its current loop but produces no done.
    task automatic applyStimulus(input int n, input int abort_after, input bit extra_start, input bit inject);
        exp_rec_t e;
        int full;
        int injected;
        full = n * 4 * H;
        if (n == 0) begin
            e.busy_len = 0;
            e.done     = 1'b1;
        end else if ((abort_after >= 0) && (abort_after < full)) begin
            e.busy_len = (abort_after / (4 * H) + 1) * 4 * H;
            e.done     = 1'b0;
        end else begin
            e.busy_len = full;
            e.done     = 1'b1;
        end
        @(posedge clk); #1;
        start  = 1'b1;
        cycles = 8'(n);
        sb.push_back(e);
        injected = 0;
        for (int w = 0; w < e.busy_len + 3; w++) begin
            @(posedge clk); #1;
            start  = extra_start && (w == 3);
            cycles = start ? 8'(n + 2) : 8'(n);
            abort  = (w == abort_after);
            if (inject && (rx_state == 2'd3) && (injected < 3)) begin
                fault_on  = 1'b1;
                fault_val = 1'b0;
                injected++;
            end else begin
                fault_on = 1'b0;
            end
        end
        start    = 1'b0;
        abort    = 1'b0;
        fault_on = 1'b0;
        checkOutput("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic pulseClear();
        @(posedge clk); #1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cycles    = 8'd0;
        abort     = 1'b0;
        chk_en    = 1'b1;
        clr_err   = 1'b0;
        fault_on  = 1'b0;
        fault_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_c_out", int'(c_out), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_mstate", int'(mstate), 0);
        checkOutput("rst_mismatch", int'(mismatch), 0);
        checkOutput("rst_err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;

        applyStimulus(1, -1, 1'b0, 1'b0);
        applyStimulus(3, -1, 1'b0, 1'b0);
        checkOutput("err_after_runs", int'(err_cnt), 0);
        applyStimulus(2, 2 * H - 1, 1'b0, 1'b0);
        applyStimulus(2, 4 * H - 1, 1'b0, 1'b0);
        applyStimulus(1, 4 * H, 1'b0, 1'b0);
        applyStimulus(0, -1, 1'b0, 1'b0);
        applyStimulus(2, -1, 1'b1, 1'b0);

        applyStimulus(1, -1, 1'b0, 1'b1);
        checkOutput("fault_mismatch", int'(mismatch), 1);
        checkOutput("fault_err_cnt", int'(err_cnt), 3);
        pulseClear();
        checkOutput("clr_mismatch", int'(mismatch), 0);
        checkOutput("clr_err_cnt", int'(err_cnt), 0);

        @(posedge clk); #1;
        fault_on  = 1'b1;
        fault_val = 1'b1;
        repeat (260) @(posedge clk);
        #1;
        fault_on = 1'b0;
        checkOutput("sat_err_cnt", int'(err_cnt), 255);
        pulseClear();

        for (int i = 0; i < 10; i++) begin
            int n;
            int ab;
            n  = int'($urandom_range(0, 3));
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n * 4 * H + 1)) : -1;
            chk_en = 1'($urandom_range(0, 1));
            applyStimulus(n, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk_en = 1'b1;
        pulseClear();

        @(posedge clk); #1;
        start  = 1'b1;
        cycles = 8'd5;
        begin
            exp_rec_t e;
            e.busy_len = 5 * 4 * H;
            e.done     = 1'b1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkOutput("async_rst_c_out", int'(c_out), 0);
        checkOutput("async_rst_busy", int'(busy), 0);
        checkOutput("async_rst_done", int'(done), 0);
        checkOutput("async_rst_mstate", int'(mstate), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(1, -1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
